mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  Memory stage between execute and write. Takes the effective address and store data for the current instruction.
//  Runs a req/ack transaction on the data-memory bus for loads (DECODE_L_TYPE) and stores (DECODE_S_TYPE).
//  Aligns and sign/zero-extends load data and drives it to write.mem_i.
//  Pulses wd_q_readin_o so the write stage latches its result.
// PARAMETERS
//  TIMEOUT  16  cycles of req without ack before bus error; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk            in   1   single clock; all state updates on posedge clk
//  reset          in   1   synchronous, active-high reset
//  start_i        in   1   one-cycle pulse: ir_i/addr_i/sdata_i valid, begin stage
//  ir_i           in   32  instruction; [6:0] opcode, [14:12] funct3
//  addr_i         in   32  effective address from execute (rs1+imm)
//  sdata_i        in   32  store data (rs2)
//  dmem_req_o     out  1   bus request, held until ack
//  dmem_we_o      out  1   1=store, 0=load
//  dmem_addr_o    out  32  word address {addr_i[31:2],2'b00}
//  dmem_be_o      out  4   byte enables
//  dmem_wdata_o   out  32  store data shifted to byte lane
//  dmem_ack_i     in   1   transaction complete; rdata valid same cycle
//  dmem_rdata_i   in   32  read word
//  mem_o          out  32  extended load result -> write.mem_i
//  wd_q_readin_o  out  1   one-cycle strobe -> write.wd_q_readin_i
//  busy_o         out  1   high in any state other than IDLE
//  misalign_o     out  1   one-cycle pulse, misaligned access (no bus traffic)
//  bus_err_o      out  1   one-cycle pulse, ack timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; mem_o=0; timeout counter=0.
//  FSM states: IDLE, REQ, DONE.
//  IDLE, start_i=1, opcode not L/S:
//   - go to DONE; no bus traffic; mem_o holds its value.
//  IDLE, start_i=1, L/S, aligned:
//   - latch ir/addr/sdata; go to REQ.
//   - dmem_req_o rises the next cycle.
//  IDLE, start_i=1, misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
//   - go to DONE; misalign_o pulses together with wd_q_readin_o.
//  REQ:
//   - req/we/addr/be/wdata stay stable until ack.
//   - ack=1: latch extended rdata (loads only) into mem_o; go to DONE.
//   - Counter increments every REQ cycle without ack.
//   - Counter reaches TIMEOUT: drop req; go to DONE; bus_err_o pulses in DONE.
//  DONE: wd_q_readin_o=1 for exactly one cycle; go to IDLE.
//  Minimum latency: start at cycle 0, ack in cycle 1 -> mem_o valid and wd_q_readin_o high in cycle 2.
//  start_i while busy_o=1 is ignored; upstream must not issue it.
//  Loads (funct3):
//   - 000 LB, 100 LBU: lane addr[1:0], sign/zero-extend byte.
//   - 001 LH, 101 LHU: lane addr[1], sign/zero-extend half.
//   - 010 LW: whole word.
//   - Any other funct3 is treated as LW.
//  Stores (funct3):
//   - 000 SB: be=4'b0001<<addr[1:0], wdata={4{sdata[7:0]}}.
//   - 001 SH: be=addr[1]?1100:0011, wdata={2{sdata[15:0]}}.
//   - 010 SW: be=1111.
//   - Stores leave mem_o unchanged.
//  Ack outside REQ is ignored. Reset in REQ drops req the next cycle; no strobe is issued.
// STRUCTURE
//  Opcode constants (DECODE_L_TYPE, DECODE_S_TYPE) come from opcode.v.
//  Add FUNCT3_B/H/W/BU/HU defines to opcode.v.
//  Add FSM state localparams to opcode.v, shared with stage sequencing.
//  Sub-module load_align: combinational (rdata, addr[1:0], funct3) -> 32-bit extended result.
//  Store lane/byte-enable generation stays inline.
// TESTING
//  1. LW addr=0x100, rdata=0xDEADBEEF, ack after 3 cycles -> addr_o=0x100, be=1111, mem_o=0xDEADBEEF, one strobe.
//  2. LB addr=0x103, rdata=0x80AABBCC -> mem_o=0xFFFFFF80; LBU same -> 0x00000080.
//  3. SH addr=0x202, sdata=0x1234ABCD -> we=1, be=1100, wdata=0xABCDABCD; mem_o unchanged.
//  4. LW addr=0x101 -> no dmem_req_o; misalign_o and wd_q_readin_o pulse 1 cycle after start.
//  5. R-type start -> strobe next cycle, no req. Load with ack never given -> bus_err_o after TIMEOUT=16 REQ cycles.
//  6. Reset asserted mid-REQ -> req low next cycle, busy_o=0, no strobe; next LW completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: opcode/funct3 encodings, FSM states,
// access-size decode and the alignment rule used by both loads and stores.
// No ports; imported by mem_access and mem_access_load_align.
package mem_access_pkg;

  // Major opcodes (ir[6:0]) that use the data-memory bus.
  localparam logic [6:0] DECODE_L_TYPE = 7'b0000011;
  localparam logic [6:0] DECODE_S_TYPE = 7'b0100011;

  // funct3 (ir[14:12]) access encodings for loads and stores.
  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  // Stage sequencing states, shared with neighbouring stage controllers.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Size comes from funct3[1:0] only; funct3[2] selects zero-extension for
  // loads. Encodings with funct3[1]=1 fall back to a full word.
  function automatic size_t access_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   access_size = SZ_BYTE;
      2'b01:   access_size = SZ_HALF;
      default: access_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      default: is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load alignment: picks the addressed byte/half out of the read word and
// sign- or zero-extends it to 32 bits. Purely combinational, no backpressure.
// Ports: i_rdata (read word), i_addr_lo (addr[1:0]), i_funct3, o_data (result).
module mem_access_load_align (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  import mem_access_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  // funct3[2] marks the unsigned variants (LBU/LHU).
  assign w_sext = ~i_funct3[2];

  always_comb begin
    o_data = i_rdata;
    case (access_size(i_funct3[1:0]))
      SZ_BYTE: o_data = {{24{w_sext & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{w_sext & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: runs one req/ack data-bus transaction per load/store, aligns
// load data into mem_o and strobes wd_q_readin_o to the write stage.
// Latency: start -> strobe in 1 cycle (no bus) or ack cycle + 1; req held until
//   ack or TIMEOUT cycles. start_i while busy_o is ignored.
// Ports: clk/reset (sync, active high); start_i/ir_i/addr_i/sdata_i from execute;
//   dmem_* data-memory bus; mem_o/wd_q_readin_o to write; busy_o, misalign_o,
//   bus_err_o status pulses.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] sdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_o,
  output logic        wd_q_readin_o,
  output logic        busy_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  import mem_access_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_is_store;
  logic [2:0]         r_funct3;
  logic [31:0]        r_addr;
  logic [31:0]        r_sdata;
  logic [31:0]        r_mem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_misalign;
  logic               r_bus_err;

  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3_in;
  logic               w_is_load;
  logic               w_is_store;
  logic               w_misalign_in;
  logic               w_start_bus;
  logic               w_timeout;
  logic [31:0]        w_load_data;
  logic [3:0]         w_store_be;
  logic [31:0]        w_store_wdata;
  logic               w_unused_ir;

  assign w_opcode      = ir_i[6:0];
  assign w_funct3_in   = ir_i[14:12];
  assign w_is_load     = (w_opcode == DECODE_L_TYPE);
  assign w_is_store    = (w_opcode == DECODE_S_TYPE);
  assign w_misalign_in = (w_is_load | w_is_store) &
                         is_misaligned(access_size(w_funct3_in[1:0]), addr_i[1:0]);
  assign w_start_bus   = (w_is_load | w_is_store) & ~w_misalign_in;
  // rd/rs fields and upper immediate bits are not needed in this stage.
  assign w_unused_ir   = &{1'b0, ir_i[31:15], ir_i[11:7]};

  // Last REQ cycle without ack: the counter already holds TIMEOUT-1 misses,
  // so req is high for exactly TIMEOUT cycles before giving up.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  mem_access_load_align u_load_align (
    .i_rdata   (dmem_rdata_i),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  // Store lane placement: data is replicated across lanes, be selects the target.
  always_comb begin
    w_store_be    = 4'b1111;
    w_store_wdata = r_sdata;
    case (access_size(r_funct3[1:0]))
      SZ_BYTE: begin
        w_store_be    = 4'b0001 << r_addr[1:0];
        w_store_wdata = {4{r_sdata[7:0]}};
      end
      SZ_HALF: begin
        w_store_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_store_wdata = {2{r_sdata[15:0]}};
      end
      default: begin
        w_store_be    = 4'b1111;
        w_store_wdata = r_sdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus outputs are gated by state so nothing leaks onto the bus outside REQ.
  always_comb begin
    w_state_nxt   = r_state;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    dmem_addr_o   = 32'h0;
    dmem_be_o     = 4'b0000;
    dmem_wdata_o  = 32'h0;
    wd_q_readin_o = 1'b0;
    misalign_o    = 1'b0;
    bus_err_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = w_start_bus ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = r_is_store;
        dmem_addr_o  = {r_addr[31:2], 2'b00};
        dmem_be_o    = r_is_store ? w_store_be : 4'b1111;
        dmem_wdata_o = r_is_store ? w_store_wdata : 32'h0;
        if (dmem_ack_i || w_timeout) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        wd_q_readin_o = 1'b1;
        misalign_o    = r_misalign;
        bus_err_o     = r_bus_err;
        w_state_nxt   = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= 32'h0;
      r_sdata    <= 32'h0;
      r_mem      <= 32'h0;
      r_cnt      <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_bus_err <= 1'b0;
          if (start_i) begin
            r_is_store <= w_is_store;
            r_funct3   <= w_funct3_in;
            r_addr     <= addr_i;
            r_sdata    <= sdata_i;
            r_misalign <= w_misalign_in;
          end
        end
        ST_REQ: begin
          // Ack wins over a timeout landing in the same cycle.
          if (dmem_ack_i) begin
            if (!r_is_store) begin
              r_mem <= w_load_data;
            end
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o = (r_state != ST_IDLE);
  assign mem_o  = r_mem;

endmodule
